// File: rtl/gamma_lcg_generator.sv
// gamma_lcg_generator
// Linear-congruential key-stream source for the decoder's modular subtractor.
// Each accepted word advances the state G <- (MULT_A*G + INC_C) mod 2^WIDTH,
// so gamma stays aligned with the ciphertext symbol it is subtracted from.
// Optional build macro GAMMA_PERIOD_CHECK_EN adds a period_wrap pulse that
// fires when the generated sequence returns to the first word after seeding.
module gamma_lcg_generator #(
  parameter int WIDTH  = 8,
  parameter int MULT_A = 5,
  parameter int INC_C  = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             gen_clear,
  input  logic             gamma_ready,
  output logic             gamma_valid,
  output logic [WIDTH-1:0] gamma,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
`ifdef GAMMA_PERIOD_CHECK_EN
  ,
  output logic             period_wrap
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int PROD_W = WIDTH + 3;

  state_t           state_q;
  logic [WIDTH-1:0] gamma_q;
  logic             vld_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] gamma_step_d;
  logic [WIDTH-1:0] seed_step_d;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             xfer_d;

`ifdef GAMMA_PERIOD_CHECK_EN
  logic [WIDTH-1:0] ref_q;
  logic             wrap_q;
`endif

  // One LCG step; the product is formed wider than the word and the
  // modulo 2^WIDTH wrap is simply the truncation back to WIDTH bits.
  function automatic logic [WIDTH-1:0] lcg_step(input logic [WIDTH-1:0] g);
    logic [PROD_W-1:0] p;
    p = PROD_W'(MULT_A) * PROD_W'(g) + PROD_W'(INC_C);
    return p[WIDTH-1:0];
  endfunction

  // Accepted-word counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Next-state candidates: advance from the current word or from a new seed.
  always_comb begin
    gamma_step_d = lcg_step(gamma_q);
    seed_step_d  = lcg_step(seed);
    cnt_inc_d    = cnt_sat_inc(cnt_q);
    xfer_d       = (state_q == RUN) && vld_q && gamma_ready;
  end

  // Control FSM with registered outputs; clear beats load, load beats transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gamma_q <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef GAMMA_PERIOD_CHECK_EN
      ref_q   <= '0;
      wrap_q  <= 1'b0;
`endif
    end else begin
`ifdef GAMMA_PERIOD_CHECK_EN
      wrap_q <= 1'b0;
`endif
      if (gen_clear) begin
        state_q <= IDLE;
        vld_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else if (seed_load) begin
        state_q <= RUN;
        gamma_q <= seed_step_d;
        vld_q   <= 1'b1;
        busy_q  <= 1'b1;
        cnt_q   <= '0;
`ifdef GAMMA_PERIOD_CHECK_EN
        ref_q   <= seed_step_d;
`endif
      end else if (xfer_d) begin
        gamma_q <= gamma_step_d;
        cnt_q   <= cnt_inc_d;
`ifdef GAMMA_PERIOD_CHECK_EN
        wrap_q  <= (gamma_step_d == ref_q);
`endif
      end
    end
  end

  assign gamma_valid = vld_q;
  assign gamma       = gamma_q;
  assign busy        = busy_q;
  assign word_cnt    = cnt_q;
`ifdef GAMMA_PERIOD_CHECK_EN
  assign period_wrap = wrap_q;
`endif

endmodule

// File: doc/gamma_lcg_generator.md
Name: gamma_lcg_generator

Overview:
Produces the 8-bit gamma (key-stream) word consumed by the decoder's modular subtractor as its b operand.
- Recurrence: G(i+1) = (A*G(i) + C) mod 2^WIDTH, seeded by a load strobe.
- Presents one word at a time on a valid/ready handshake.
- Advances only when the downstream stage accepts a word, so gamma and ciphertext stay aligned symbol-for-symbol.

Parameters:
WIDTH, 8, gamma word width; matches the subtractor's b operand.
MULT_A, 5, LCG multiplier; (MULT_A-1) must be divisible by 4 for full period.
INC_C, 3, LCG increment; must be odd for full period 2^WIDTH.
CNT_W, 16, width of the accepted-word counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
seed_load  in  1  one-cycle strobe; loads seed and starts generation.
seed  in  WIDTH  initial state G(0), sampled when seed_load=1.
gen_clear  in  1  synchronous stop; returns the block to IDLE.
gamma_ready  in  1  downstream accepts the current gamma word.
gamma_valid  out  1  gamma holds a valid word.
gamma  out  WIDTH  current gamma word.
busy  out  1  high in state RUN.
word_cnt  out  CNT_W  number of words accepted since the last seed load.

Behaviour:
- Reset is asynchronous and active-low on rst_n; all state is clocked on clk.
- Reset values: state=IDLE, gamma=0, gamma_valid=0, busy=0, word_cnt=0.
- FSM states:
  - IDLE: gamma_valid=0, gamma holds its last value.
  - RUN: gamma_valid=1, busy=1.
- IDLE -> RUN on seed_load=1.
  - Next cycle gamma = (MULT_A*seed + INC_C) mod 2^WIDTH, gamma_valid=1, word_cnt=0.
  - Latency from load to first valid word: 1 cycle.
- In RUN, a transfer occurs when gamma_valid && gamma_ready.
  - Next cycle: gamma = (MULT_A*gamma + INC_C) mod 2^WIDTH, word_cnt += 1.
  - gamma_valid remains 1, so back-to-back transfers run at 1 word/cycle.
- In RUN with gamma_ready=0: gamma and word_cnt hold, gamma_valid stays 1.
  - gamma must not change while valid and not accepted.
- seed_load in RUN reseeds: next gamma is derived from the new seed, word_cnt=0.
- seed_load and a transfer in the same cycle: the current word counts as consumed, but seed_load wins, so the next gamma comes from the new seed and word_cnt=0.
- gen_clear=1: next state IDLE, gamma_valid=0, word_cnt holds.
- gen_clear and seed_load in the same cycle: gen_clear wins.
- Arithmetic:
  - Product is computed at WIDTH+3 bits minimum, then truncated to WIDTH bits; no saturation.
  - Wrap-around mod 2^WIDTH is the defined behaviour.
- word_cnt saturates at 2^CNT_W - 1; it does not wrap.
- rst_n asserted mid-stream: immediate return to reset values regardless of handshake state.

Optional Feature:
Macro GAMMA_PERIOD_CHECK_EN.
- Defined:
  - Adds output period_wrap (1 bit, reset 0).
  - The first word after each seed load is captured as a reference.
  - period_wrap pulses high for one cycle when a newly generated word equals that reference, i.e. the sequence has completed a full period.
  - Reseed re-captures the reference.
- Undefined: no port, no reference register; all other behaviour identical.

Test Plan:
- Reset then seed_load with seed=0x00, gamma_ready=1 -> gamma sequence 0x03, 0x12, 0x5D, 0xD4 on consecutive cycles; word_cnt reaches 4 after four transfers.
- seed=0x10, gamma_ready=0 for 5 cycles -> gamma stays 0x53 with valid=1; word_cnt=0; first transfer on ready=1 -> next gamma 0xA2.
- RUN after 3 transfers from seed 0x00, then seed_load seed=0x10 coincident with gamma_ready=1 -> next gamma 0x53, word_cnt=0.
- gen_clear asserted in RUN together with seed_load -> gamma_valid=0 next cycle, busy=0, word_cnt unchanged.
- rst_n pulsed low mid-stream with ready=1 -> outputs 0 asynchronously; no transfer counted after release until a new seed_load.
- With GAMMA_PERIOD_CHECK_EN: seed 0x00, ready=1 held -> period_wrap pulses exactly once, when the 257th word (0x03) is presented after 256 transfers.
